ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Complements the existing keyboard receive path and sits beside it on the shared PS2_CLK/PS2_DAT pins.
- Drives the open-drain lines through active-high pull-low enables. Top level ties each pin as: enable ? 1'b0 : 1'bz.
- Reports per-byte completion or failure to the game logic.

---
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter for one command byte over open-drain clock/data
// Optional PS2_HOST_TX_RETRY_EN: a NACKed or timed-out byte is retried up to twice before error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK_SAMPLE, WAIT_IDLE, FAIL
    } state_t;

    state_t             state_q, state_d;
    logic               clk_meta_q, clk_sync_q, clk_prev_q;
    logic               dat_meta_q, dat_sync_q;
    logic [7:0]         data_q, data_d;
    logic               parity_q, parity_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               ack_q, ack_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               tx_ready_q, busy_q;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               clk_fe;
    logic               tmo_hit;
    logic               fail_c;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]         retry_q, retry_d;
`endif

    assign clk_fe  = clk_prev_q & ~clk_sync_q;
    assign tmo_hit = (tmo_cnt_q >= TMO_LAST);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        bit_cnt_d = bit_cnt_q;
        ack_d     = ack_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail_c    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d   = 2'd0;
`endif
                end
            end
            INHIBIT: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                if (inh_cnt_q >= INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_ONE;
                end
            end
            RTS: begin
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b1;
                tmo_cnt_d = '0;
                bit_cnt_d = 4'd0;
                state_d   = SEND;
            end
            SEND: begin
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                if (tmo_hit) begin
                    fail_c = 1'b1;
                end else if (clk_fe) begin
                    // Data changes while the device holds the clock low
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else if (bit_cnt_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                    end else begin
                        ack_d   = dat_sync_q;
                        state_d = ACK_SAMPLE;
                    end
                end
            end
            ACK_SAMPLE: begin
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                if (tmo_hit || ack_q) begin
                    fail_c = 1'b1;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                if (tmo_hit) begin
                    fail_c = 1'b1;
                end else if (clk_sync_q && dat_sync_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            FAIL: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fail_c) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d   = retry_q + 2'd1;
                inh_cnt_d = '0;
                clk_oe_d  = 1'b1;
                state_d   = INHIBIT;
            end else begin
                error_d = 1'b1;
                state_d = FAIL;
            end
`else
            error_d = 1'b1;
            state_d = FAIL;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            state_q    <= IDLE;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            bit_cnt_q  <= 4'd0;
            ack_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q    <= 2'd0;
`endif
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_q      <= ack_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a behavioural PS/2 keyboard model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TMO  = 4000;
    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_line, ps2_dat_line;

    int checks = 0;
    int failures = 0;
    int done_seen = 0, error_seen = 0, inh_seen = 0, overlap_seen = 0;
    int err_oe_bad = 0, bad_start = 0;
    logic clk_oe_prev = 1'b0;
    logic ready_prev = 1'b0;

    assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

    always #100 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (error === 1'b1) error_seen <= error_seen + 1;
        if (done === 1'b1 && error === 1'b1) overlap_seen <= overlap_seen + 1;
        if (error === 1'b1 && (ps2_clk_oe || ps2_dat_oe)) err_oe_bad <= err_oe_bad + 1;
        if (ps2_clk_oe && !clk_oe_prev) begin
            inh_seen <= inh_seen + 1;
            if (!ready_prev && !reset) bad_start <= bad_start + 1;
        end
        clk_oe_prev <= ps2_clk_oe;
        ready_prev  <= tx_ready;
    end

    task automatic wait_rts(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1 && busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Keyboard: clocks the frame in, samples each bit on the rising clock edge
    task automatic dev_frame(input logic do_ack, input int stop_at,
                             output logic [10:0] bits, output logic host_dat_at_ack,
                             output logic ok);
        bits = '0;
        host_dat_at_ack = 1'b1;
        wait_rts(ok);
        if (ok) begin
            repeat (HALF) @(negedge clk);
            bits[0] = ps2_dat_line;
            for (int i = 1; i <= 11; i++) begin
                dev_clk_low = 1'b1;
                if (i == stop_at) begin
                    repeat (HALF / 2) @(negedge clk);
                    return;
                end
                repeat (HALF) @(negedge clk);
                if (i == 11) host_dat_at_ack = ps2_dat_oe;
                dev_clk_low = 1'b0;
                if (i <= 10) bits[i] = ps2_dat_line;
                if (i == 10 && do_ack) begin
                    repeat (HALF / 2) @(negedge clk);
                    dev_dat_low = 1'b1;
                    repeat (HALF / 2) @(negedge clk);
                end else if (i == 11) begin
                    dev_dat_low = 1'b0;
                    repeat (10) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release: got ready,busy=%b expected 10", {tx_ready, busy});
        end
    endtask

    task automatic test_ack_ed();
        int d0, e0;
        logic ok, fok, hd;
        logic [10:0] bits;
        d0 = done_seen; e0 = error_seen;
        send_byte(8'hED, ok);
        dev_frame(1'b1, 0, bits, hd, fok);
        repeat (5) @(negedge clk);
        checks++;
        if ({ok, fok} !== 2'b11) begin
            failures++;
            $display("FAIL ed_handshake: got ready,rts=%b expected 11", {ok, fok});
        end
        checks++;
        if (bits !== 11'b1_1_11101101_0) begin
            failures++;
            $display("FAIL ed_frame: got %b expected 11111011010", bits);
        end
        checks++;
        if (hd !== 1'b0) begin
            failures++;
            $display("FAIL ed_ack_release: got dat_oe=%b expected 0", hd);
        end
        checks++;
        if (done_seen - d0 !== 1 || error_seen - e0 !== 0) begin
            failures++;
            $display("FAIL ed_pulses: got done=%0d error=%0d expected 1 0",
                     done_seen - d0, error_seen - e0);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ed_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_parity();
        logic [7:0] pb [3] = '{8'h01, 8'hFF, 8'h00};
        logic       pp [3] = '{1'b0, 1'b1, 1'b1};
        logic ok, fok, hd;
        logic [10:0] bits;
        int d0;
        for (int k = 0; k < 3; k++) begin
            d0 = done_seen;
            send_byte(pb[k], ok);
            dev_frame(1'b1, 0, bits, hd, fok);
            repeat (5) @(negedge clk);
            checks++;
            if (bits !== {1'b1, pp[k], pb[k], 1'b0} || !ok || !fok) begin
                failures++;
                $display("FAIL parity_frame_%0h: got %b expected %b", pb[k], bits,
                         {1'b1, pp[k], pb[k], 1'b0});
            end
            checks++;
            if (done_seen - d0 !== 1) begin
                failures++;
                $display("FAIL parity_done_%0h: got %0d expected 1", pb[k], done_seen - d0);
            end
        end
    endtask

    task automatic test_nack();
        int d0, e0, i0, b0, attempts;
        logic ok, fok, hd;
        logic [10:0] bits;
        d0 = done_seen; e0 = error_seen; i0 = inh_seen; b0 = err_oe_bad;
`ifdef PS2_HOST_TX_RETRY_EN
        attempts = 3;
`else
        attempts = 1;
`endif
        send_byte(8'hED, ok);
        for (int a = 0; a < attempts; a++) dev_frame(1'b0, 0, bits, hd, fok);
        repeat (5) @(negedge clk);
        checks++;
        if (error_seen - e0 !== 1 || done_seen - d0 !== 0) begin
            failures++;
            $display("FAIL nack_pulses: got error=%0d done=%0d expected 1 0",
                     error_seen - e0, done_seen - d0);
        end
        checks++;
        if (inh_seen - i0 !== attempts) begin
            failures++;
            $display("FAIL nack_inhibits: got %0d expected %0d", inh_seen - i0, attempts);
        end
        checks++;
        if (err_oe_bad - b0 !== 0 || {ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
            failures++;
            $display("FAIL nack_release: got %0d pulses with oe, oe=%b expected 0 00",
                     err_oe_bad - b0, {ps2_clk_oe, ps2_dat_oe});
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL nack_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_timeout();
        int n, i0, e0, limit;
        logic ok;
        i0 = inh_seen; e0 = error_seen;
        send_byte(8'h55, ok);
        n = 0;
        while (ps2_dat_oe !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== INH) begin
            failures++;
            $display("FAIL inhibit_len: got %0d expected %0d", n, INH);
        end
        while (ps2_clk_oe !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
`ifdef PS2_HOST_TX_RETRY_EN
        limit = 3 * (TMO + INH + 10);
`else
        limit = TMO + 50;
`endif
        n = 0;
        while (error !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
`ifdef PS2_HOST_TX_RETRY_EN
        checks++;
        if (inh_seen - i0 !== 3 || n <= 2 * TMO) begin
            failures++;
            $display("FAIL timeout_retry: got inhibits=%0d cycles=%0d expected 3 >%0d",
                     inh_seen - i0, n, 2 * TMO);
        end
`else
        checks++;
        if (n !== TMO) begin
            failures++;
            $display("FAIL timeout_len: got %0d expected %0d", n, TMO);
        end
`endif
        checks++;
        if ({error, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
            failures++;
            $display("FAIL timeout_release: got err,clk_oe,dat_oe=%b expected 100",
                     {error, ps2_clk_oe, ps2_dat_oe});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error_seen - e0 !== 1) begin
            failures++;
            $display("FAIL timeout_pulses: got %0d expected 1", error_seen - e0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        logic ok, fok, hd;
        logic [10:0] bits;
        d0 = done_seen; e0 = error_seen;
        send_byte(8'hED, ok);
        dev_frame(1'b1, 5, bits, hd, fok);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b011) begin
            failures++;
            $display("FAIL mid_bit5_state: got clk_oe,dat_oe,busy=%b expected 011",
                     {ps2_clk_oe, ps2_dat_oe, busy});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_release: got clk_oe,dat_oe,busy=%b expected 000",
                     {ps2_clk_oe, ps2_dat_oe, busy});
        end
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_seen - d0 !== 0 || error_seen - e0 !== 0) begin
            failures++;
            $display("FAIL mid_reset_pulses: got done=%0d error=%0d expected 0 0",
                     done_seen - d0, error_seen - e0);
        end
        send_byte(8'hF4, ok);
        dev_frame(1'b1, 0, bits, hd, fok);
        repeat (5) @(negedge clk);
        checks++;
        if (bits !== 11'b1_0_11110100_0 || done_seen - d0 !== 1) begin
            failures++;
            $display("FAIL f4_after_reset: got frame=%b done=%0d expected 10111101000 1",
                     bits, done_seen - d0);
        end
    endtask

    task automatic test_hold_valid();
        int d0, i0, s0, n;
        logic fok, hd;
        logic [10:0] bits;
        d0 = done_seen; i0 = inh_seen; s0 = bad_start;
        n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        tx_data = 8'hAA;
        dev_frame(1'b1, 0, bits, hd, fok);
        checks++;
        if (bits !== 11'b1_1_11101101_0) begin
            failures++;
            $display("FAIL hold_first_frame: got %b expected 11111011010", bits);
        end
        n = 0;
        while (inh_seen - i0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        checks++;
        if (inh_seen - i0 !== 2) begin
            failures++;
            $display("FAIL hold_second_start: got %0d inhibits expected 2", inh_seen - i0);
        end
        dev_frame(1'b1, 0, bits, hd, fok);
        repeat (5) @(negedge clk);
        checks++;
        if (bits !== 11'b1_1_10101010_0) begin
            failures++;
            $display("FAIL hold_second_frame: got %b expected 11101010100", bits);
        end
        checks++;
        if (done_seen - d0 !== 2 || bad_start - s0 !== 0) begin
            failures++;
            $display("FAIL hold_sequence: got done=%0d early_starts=%0d expected 2 0",
                     done_seen - d0, bad_start - s0);
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_seen !== 0) begin
            failures++;
            $display("FAIL done_error_overlap: got %0d expected 0", overlap_seen);
        end
    endtask

    initial begin
        test_reset();
        test_ack_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_hold_valid();
        test_no_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
